// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port block RAM.
// be_merge works on a fixed maximum width; callers zero-extend and truncate.
package bram_pkg;

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam int unsigned MAX_DATA_W = 512;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Replace each byte of old_w whose enable is set with the same byte of new_w.
  function automatic logic [MAX_DATA_W-1:0] be_merge(input logic [MAX_DATA_W-1:0] old_w,
                                                     input logic [MAX_DATA_W-1:0] new_w,
                                                     input logic [MAX_BE_W-1:0]   be);
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Pure storage: synchronous byte-enabled write, registered read, no reset.
// A read of the address being written returns the old contents; the top merges.
module bram_sdp_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with power-up/on-demand clear sweep and write-first bypass.
// Define BRAM_SDP_OUTREG_EN for an extra output register (2-cycle read latency).
module bram_sdp
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              ren,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr,
  output logic              init_busy
);

  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;

  logic              run;
  logic              wr_in_range, rd_in_range;
  logic              port_we, rd_fire;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [BE_W-1:0]   arr_wbe;

  logic [BE_W-1:0]   byp_be_q;
  logic [DATA_W-1:0] byp_data_q;
  logic              oor_q, have_q, vld1_q;
  logic [DATA_W-1:0] merged;

  assign run         = (state_q == S_RUN);
  assign init_busy   = ~run;
  assign wr_in_range = ({1'b0, wr_addr} < DepthExt);
  assign rd_in_range = ({1'b0, rd_addr} < DepthExt);

  // clr in S_RUN drops any port access in the same cycle.
  assign port_we = run & wen & ~clr & wr_in_range & (|wr_be);
  assign rd_fire = run & ren & ~clr;

  always_comb begin
    arr_we    = port_we;
    arr_waddr = wr_addr;
    arr_wdata = wr_data;
    arr_wbe   = wr_be;
    if (!run) begin
      arr_we    = 1'b1;
      arr_waddr = ptr_q;
      arr_wdata = '0;
      arr_wbe   = '1;
    end
  end

  assign arr_re = rd_fire & rd_in_range;

  bram_sdp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wbe   (arr_wbe),
    .re    (arr_re),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (ptr_q == LastAddr) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        S_RUN: begin
          if (clr) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
          end
        end
        default: begin
          state_q <= S_INIT;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Bypass state travels with the read so the output holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_be_q   <= '0;
      byp_data_q <= '0;
      oor_q      <= 1'b0;
      have_q     <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      vld1_q <= rd_fire;
      if (rd_fire) begin
        byp_be_q   <= (port_we && (wr_addr == rd_addr)) ? wr_be : '0;
        byp_data_q <= wr_data;
        oor_q      <= ~rd_in_range;
        have_q     <= 1'b1;
      end
    end
  end

  always_comb begin
    merged = DATA_W'(be_merge(MAX_DATA_W'(arr_rdata), MAX_DATA_W'(byp_data_q),
                              MAX_BE_W'(byp_be_q)));
    if (!have_q || oor_q) merged = '0;
  end

`ifdef BRAM_SDP_OUTREG_EN
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= vld1_q;
      if (vld1_q) rd_data_q <= merged;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  assign rd_data  = merged;
  assign rd_valid = vld1_q;
`endif

endmodule

// File: tb/tb_bram_sdp.sv
// Directed self-checking bench: a DEPTH=16 instance for the main function and
// a DEPTH=12 instance for out-of-range addressing.
module tb_bram_sdp;

`ifdef BRAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic        wen_a = 0, ren_a = 0, clr_a = 0;
  logic [3:0]  wr_addr_a = 0, rd_addr_a = 0, wr_be_a = 0;
  logic [31:0] wr_data_a = 0, rd_data_a;
  logic        rd_valid_a, init_busy_a;

  // DEPTH=12 instance
  logic        wen_b = 0, ren_b = 0, clr_b = 0;
  logic [3:0]  wr_addr_b = 0, rd_addr_b = 0, wr_be_b = 0;
  logic [31:0] wr_data_b = 0, rd_data_b;
  logic        rd_valid_b, init_busy_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  bram_sdp #(.DATA_W(32), .DEPTH(16)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen_a),
    .wr_addr   (wr_addr_a),
    .wr_data   (wr_data_a),
    .wr_be     (wr_be_a),
    .ren       (ren_a),
    .rd_addr   (rd_addr_a),
    .rd_data   (rd_data_a),
    .rd_valid  (rd_valid_a),
    .clr       (clr_a),
    .init_busy (init_busy_a)
  );

  bram_sdp #(.DATA_W(32), .DEPTH(12)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen_b),
    .wr_addr   (wr_addr_b),
    .wr_data   (wr_data_b),
    .wr_be     (wr_be_b),
    .ren       (ren_b),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .rd_valid  (rd_valid_b),
    .clr       (clr_b),
    .init_busy (init_busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wen_a = 1; wr_addr_a = a; wr_data_a = d; wr_be_a = be;
    tick();
    wen_a = 0; wr_be_a = 0;
  endtask

  task automatic rd_a(input logic [3:0] a, output logic [31:0] d, output logic v);
    ren_a = 1; rd_addr_a = a;
    tick();
    ren_a = 0;
    repeat (LAT - 1) tick();
    d = rd_data_a; v = rd_valid_a;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [31:0] d);
    wen_b = 1; wr_addr_b = a; wr_data_b = d; wr_be_b = 4'hF;
    tick();
    wen_b = 0; wr_be_b = 0;
  endtask

  task automatic rd_b(input logic [3:0] a, output logic [31:0] d, output logic v);
    ren_b = 1; rd_addr_b = a;
    tick();
    ren_b = 0;
    repeat (LAT - 1) tick();
    d = rd_data_b; v = rd_valid_b;
  endtask

  task automatic test_reset();
    int cnt, cnt_b;
    logic [31:0] d;
    logic v;
    rst_n = 0;
    repeat (2) tick();
    total_cnt++;
    if (init_busy_a !== 1'b1 || rd_valid_a !== 1'b0 || rd_data_a !== 32'h0)
      $display("FAIL reset_values busy=%b valid=%b data=%h, required busy=1 valid=0 data=0",
               init_busy_a, rd_valid_a, rd_data_a);
    else pass_cnt++;
    rst_n = 1;
    cnt = 0; cnt_b = 0;
    while (init_busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (init_busy_b === 1'b0 && cnt_b == 0) cnt_b = cnt;
    end
    total_cnt++;
    if (cnt != 16) $display("FAIL sweep_len_16 got %0d edges, required 16", cnt);
    else pass_cnt++;
    total_cnt++;
    if (cnt_b != 12) $display("FAIL sweep_len_12 got %0d edges, required 12", cnt_b);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      rd_a(4'(i), d, v);
      total_cnt++;
      if (d !== 32'h0 || v !== 1'b1)
        $display("FAIL init_zero addr %0d data=%h valid=%b, required 0/1", i, d, v);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (rd_valid_a !== 1'b0) $display("FAIL valid_pulse got %b, required 0", rd_valid_a);
    else pass_cnt++;
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    logic v;
    wr_a(4'd5, 32'hDEADBEEF, 4'hF);
    wr_a(4'd5, 32'h0000AA00, 4'b0010);
    rd_a(4'd5, d, v);
    total_cnt++;
    if (d !== 32'hDEADAAEF || v !== 1'b1)
      $display("FAIL byte_write data=%h valid=%b, required DEADAAEF/1", d, v);
    else pass_cnt++;
  endtask

  task automatic test_rdw();
    logic [31:0] d;
    logic v;
    wr_a(4'd3, 32'hAABBCCDD, 4'hF);
    wen_a = 1; wr_addr_a = 3; wr_data_a = 32'h11223344; wr_be_a = 4'b1100;
    ren_a = 1; rd_addr_a = 3;
    tick();
    wen_a = 0; wr_be_a = 0; ren_a = 0;
    repeat (LAT - 1) tick();
    total_cnt++;
    if (rd_data_a !== 32'h1122CCDD || rd_valid_a !== 1'b1)
      $display("FAIL rdw_bypass data=%h valid=%b, required 1122CCDD/1", rd_data_a, rd_valid_a);
    else pass_cnt++;
    wr_a(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd_a(4'd3, d, v);
    total_cnt++;
    if (d !== 32'h1122CCDD)
      $display("FAIL be_zero_noop data=%h, required 1122CCDD", d);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wr_a(4'(i), 32'h1000_0000 + 32'(i) * 32'h0011_0101, 4'hF);
    for (int i = 0; i < 16 + LAT - 1; i++) begin
      ren_a = (i < 16); rd_addr_a = 4'(i);
      tick();
      if (i >= LAT - 1) begin
        total_cnt++;
        if (rd_data_a !== 32'h1000_0000 + 32'(i - LAT + 1) * 32'h0011_0101 ||
            rd_valid_a !== 1'b1)
          $display("FAIL b2b_read addr %0d data=%h valid=%b, required %h/1", i - LAT + 1,
                   rd_data_a, rd_valid_a, 32'h1000_0000 + 32'(i - LAT + 1) * 32'h0011_0101);
        else pass_cnt++;
      end
    end
    ren_a = 0;
    tick();
  endtask

  task automatic test_clr();
    int cnt;
    logic seen_v;
    logic [31:0] d;
    logic v;
    clr_a = 1; wen_a = 1; wr_addr_a = 0; wr_data_a = 32'hFFFFFFFF; wr_be_a = 4'hF;
    ren_a = 1; rd_addr_a = 1;
    tick();
    total_cnt++;
    if (init_busy_a !== 1'b1) $display("FAIL clr_busy got %b, required 1", init_busy_a);
    else pass_cnt++;
    wr_addr_a = 2; wr_data_a = 32'h55555555;
    rd_addr_a = 2;
    cnt = 0; seen_v = rd_valid_a;
    while (init_busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (rd_valid_a === 1'b1 && init_busy_a === 1'b1) seen_v = 1;
    end
    clr_a = 0; wen_a = 0; ren_a = 0; wr_be_a = 0;
    total_cnt++;
    if (cnt != 16) $display("FAIL clr_sweep_len got %0d edges, required 16", cnt);
    else pass_cnt++;
    total_cnt++;
    if (seen_v !== 1'b0) $display("FAIL clr_ignored_read valid seen=%b, required 0", seen_v);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      rd_a(4'(i), d, v);
      total_cnt++;
      if (d !== 32'h0 || v !== 1'b1)
        $display("FAIL clr_zero addr %0d data=%h valid=%b, required 0/1", i, d, v);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    logic [31:0] d;
    logic v;
    wr_a(4'd9, 32'hCAFEF00D, 4'hF);
    rd_a(4'd9, d, v);
    clr_a = 1;
    tick();
    clr_a = 0;
    repeat (7) tick();
    total_cnt++;
    if (rd_data_a !== 32'hCAFEF00D)
      $display("FAIL hold_in_sweep data=%h, required CAFEF00D", rd_data_a);
    else pass_cnt++;
    rst_n = 0;
    #1;
    total_cnt++;
    if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b0 || init_busy_a !== 1'b1)
      $display("FAIL mid_sweep_reset data=%h valid=%b busy=%b, required 0/0/1",
               rd_data_a, rd_valid_a, init_busy_a);
    else pass_cnt++;
    tick();
    rst_n = 1;
    cnt = 0;
    while (init_busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    total_cnt++;
    if (cnt != 16) $display("FAIL resweep_len got %0d edges, required 16", cnt);
    else pass_cnt++;
  endtask

  task automatic test_oor();
    int cnt;
    logic [31:0] d;
    logic v;
    cnt = 0;
    while (init_busy_b === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 12; i++) wr_b(4'(i), 32'hB000_0000 + 32'(i));
    wr_b(4'd13, 32'hFFFFFFFF);
    rd_b(4'd13, d, v);
    total_cnt++;
    if (d !== 32'h0 || v !== 1'b1)
      $display("FAIL oor_read data=%h valid=%b, required 0/1", d, v);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      rd_b(4'(i), d, v);
      total_cnt++;
      if (d !== 32'hB000_0000 + 32'(i) || v !== 1'b1)
        $display("FAIL oor_untouched addr %0d data=%h valid=%b, required %h/1", i, d, v,
                 32'hB000_0000 + 32'(i));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_rdw();
    test_back_to_back();
    test_clr();
    test_reset_mid_sweep();
    test_oor();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
